// File: rtl/stream_tg_param_if.sv
// Valid/ready beat stream between the traffic generator and the core under test.
interface stream_tg_param_if #(
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/stream_tg_param.sv
// Burst traffic generator: programmable length, gap, payload mode and burst count,
// with data/last held stable under backpressure.
module stream_tg_param #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8,
  parameter int GAP_W  = 8,
  parameter int BCNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic [GAP_W-1:0]      cfg_gap,
  input  logic                  cfg_mode,
  input  logic [BCNT_W-1:0]     cfg_bursts,
  stream_tg_param_if.master     m_axi,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = DATA_W - 32;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t              state;
  logic                valid_q, last_q;
  logic [DATA_W-1:0]   data_q;
  logic [LEN_W-1:0]    len_q, beat_idx;
  logic [GAP_W-1:0]    gap_q, gap_cnt;
  logic                mode_q;
  logic [BCNT_W-1:0]   bursts_q, burst_idx;
  logic [PW-1:0]       inc_q;
  logic [31:0]         lfsr_q;

  logic                xfer, is_last, final_burst, gap_hit, start_burst;
  logic [PW-1:0]       inc_n;
  logic [31:0]         lfsr_n;
  logic [LEN_W-1:0]    beat_n;
  logic [BCNT_W-1:0]   burst_n;
  logic [DATA_W-1:0]   start_data;

  function automatic logic [DATA_W-1:0] pack_beat(
    input logic              sel_lfsr,
    input logic [PW-1:0]     cnt,
    input logic [31:0]       lf,
    input logic [LEN_W-1:0]  beat,
    input logic [BCNT_W-1:0] burst
  );
    logic [PW-1:0] pl;
    pl = sel_lfsr ? PW'(lf) : cnt;
    return {pl, 16'(beat), 16'(burst)};
  endfunction

  always_comb begin
    xfer        = valid_q && m_axi.ready;
    is_last     = (beat_idx == len_q);
    inc_n       = inc_q + PW'(1);
    lfsr_n      = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
    beat_n      = beat_idx + LEN_W'(1);
    burst_n     = burst_idx + BCNT_W'(1);
    final_burst = (bursts_q != '0) && (burst_n == bursts_q);
    gap_hit     = (gap_cnt + GAP_W'(1)) == gap_q;
    start_burst = ((state == IDLE) && en) ||
                  ((state == GAP) && en && gap_hit) ||
                  ((state == SEND) && xfer && is_last && !final_burst && en && (gap_q == '0));
    // A back-to-back start sees the generators and burst index already advanced by this transfer.
    start_data  = pack_beat(cfg_mode, xfer ? inc_n : inc_q, xfer ? lfsr_n : lfsr_q,
                            '0, xfer ? burst_n : burst_idx);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      len_q     <= '0;
      gap_q     <= '0;
      mode_q    <= 1'b0;
      bursts_q  <= '0;
      beat_idx  <= '0;
      burst_idx <= '0;
      gap_cnt   <= '0;
      inc_q     <= PW'(1);
      lfsr_q    <= 32'hFFFF_FFFF;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: ;
        SEND: begin
          if (xfer) begin
            inc_q  <= inc_n;
            lfsr_q <= lfsr_n;
            if (is_last) begin
              burst_idx <= burst_n;
              beat_idx  <= '0;
              valid_q   <= 1'b0;
              last_q    <= 1'b0;
              if (final_burst) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
              end else if (!en) begin
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                gap_cnt <= '0;
                state   <= GAP;
              end
            end else begin
              beat_idx <= beat_n;
              data_q   <= pack_beat(mode_q, inc_n, lfsr_n, beat_n, burst_idx);
              last_q   <= (beat_n == len_q);
            end
          end
        end
        GAP: begin
          if (!en) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        DONE: begin
          if (!en) begin
            burst_idx <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Burst start overrides whatever the case above chose for this cycle.
      if (start_burst) begin
        len_q    <= cfg_len;
        gap_q    <= cfg_gap;
        mode_q   <= cfg_mode;
        if (state == IDLE) bursts_q <= cfg_bursts;
        beat_idx <= '0;
        valid_q  <= 1'b1;
        data_q   <= start_data;
        last_q   <= (cfg_len == '0);
        busy     <= 1'b1;
        state    <= SEND;
      end
    end
  end

  assign m_axi.valid = valid_q;
  assign m_axi.data  = data_q;
  assign m_axi.last  = last_q;

endmodule

// File: tb/tb_stream_tg_param.sv
// Scoreboard bench for stream_tg_param: randomized configs and backpressure
// checked against a transfer-level reference model.
module tb_stream_tg_param;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 8;
  localparam int GAP_W  = 8;
  localparam int BCNT_W = 16;
  localparam int PW     = DATA_W - 32;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              en = 1'b0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic [GAP_W-1:0]  cfg_gap = '0;
  logic              cfg_mode = 1'b0;
  logic [BCNT_W-1:0] cfg_bursts = '0;
  logic              busy, done;

  stream_tg_param_if #(.DATA_W(DATA_W)) bus ();

  stream_tg_param #(.DATA_W(DATA_W), .LEN_W(LEN_W), .GAP_W(GAP_W), .BCNT_W(BCNT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_len(cfg_len), .cfg_gap(cfg_gap),
    .cfg_mode(cfg_mode), .cfg_bursts(cfg_bursts), .m_axi(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  beat_t exp_q[$];
  int xfer_cnt = 0;
  int done_cnt = 0;
  int exp_gap  = 0;
  bit armed    = 0;
  int rdy_mode = 0;   // 0 always, 1 pattern 1,0,0, 2 random, 3 manual
  bit man_rdy  = 1;

  // reference model state: generators advance per transfer, never per cycle
  logic [PW-1:0]     m_inc  = PW'(1);
  logic [31:0]       m_lfsr = 32'hFFFF_FFFF;
  logic [BCNT_W-1:0] m_burst = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Polynomial x^32+x^22+x^2+x+1 in right-shifting Galois form
  function automatic logic [31:0] galois_step(input logic [31:0] s);
    int taps[4] = '{32, 22, 2, 1};
    logic [31:0] poly = '0;
    foreach (taps[i]) poly[taps[i]-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
  endfunction

  task automatic push_burst(input int len, input logic mode);
    for (int b = 0; b <= len; b++) begin
      beat_t e;
      logic [PW-1:0] pl;
      pl = mode ? PW'(m_lfsr) : m_inc;
      e.data = {pl, 16'(b), 16'(m_burst)};
      e.last = (b == len);
      exp_q.push_back(e);
      m_inc  = m_inc + PW'(1);
      m_lfsr = galois_step(m_lfsr);
    end
    m_burst = m_burst + BCNT_W'(1);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_xfers(input int target);
    for (int i = 0; i < 500 && xfer_cnt != target; i++) cyc(1);
    chk("xfer_wait", 64'(xfer_cnt), 64'(target));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 64'(bus.valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_queue"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_bursts(input int len, input int gap, input logic mode, input int bursts,
                            input int rmode);
    int d0;
    cfg_len = LEN_W'(len); cfg_gap = GAP_W'(gap); cfg_mode = mode; cfg_bursts = BCNT_W'(bursts);
    exp_gap = gap; rdy_mode = rmode; armed = 0;
    for (int k = 0; k < bursts; k++) push_burst(len, mode);
    d0 = done_cnt;
    en = 1'b1;
    for (int i = 0; i < 3000 && done_cnt == d0; i++) cyc(1);
    chk("done_seen", 64'(done_cnt - d0), 64'd1);
    en = 1'b0;
    cyc(3);
    chk("done_once", 64'(done_cnt - d0), 64'd1);
    check_idle("after_done");
    m_burst = '0;
    armed = 0;
  endtask

  // ready driver
  initial begin
    int pat = 0;
    bus.ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: bus.ready = 1'b1;
        1: begin bus.ready = (pat % 3 == 0); pat++; end
        2: bus.ready = ($urandom_range(0, 3) != 0);
        default: bus.ready = man_rdy;
      endcase
    end
  end

  // monitor / scoreboard
  initial begin
    bit stall = 0;
    logic [DATA_W-1:0] pd;
    logic pl;
    int low_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall = 0;
      end else begin
        if (stall) begin
          chk("hold_valid", 64'(bus.valid), 64'd1);
          chk("hold_data", bus.data, pd);
          chk("hold_last", 64'(bus.last), 64'(pl));
        end
        if (armed) begin
          if (!bus.valid) low_cnt++;
          else begin
            chk("gap_len", 64'(low_cnt), 64'(exp_gap));
            armed = 0;
          end
        end
        if (done) done_cnt++;
        if (bus.valid && bus.ready) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got %h expected none", bus.data);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("beat_data", bus.data, e.data);
            chk("beat_last", 64'(bus.last), 64'(e.last));
          end
          if (bus.last) begin
            armed = 1;
            low_cnt = 0;
          end
        end
        stall = bus.valid && !bus.ready;
        pd = bus.data;
        pl = bus.last;
      end
    end
  end

  initial begin
    int base;
    cyc(3);
    chk("rst_valid", 64'(bus.valid), 64'd0);
    chk("rst_last", 64'(bus.last), 64'd0);
    chk("rst_data", bus.data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 1'b1;
    cyc(1);

    // LFSR payload straight from reset
    run_bursts(2, 1, 1'b1, 2, 0);
    // directed: len 3, gap 2, incrementing, 2 bursts, then with 1,0,0 backpressure
    run_bursts(3, 2, 1'b0, 2, 0);
    run_bursts(3, 2, 1'b0, 2, 1);

    // unlimited single-beat bursts, back to back
    cfg_len = '0; cfg_gap = '0; cfg_mode = 1'b0; cfg_bursts = '0;
    exp_gap = 0; rdy_mode = 3; man_rdy = 1; armed = 0;
    for (int k = 0; k < 10; k++) push_burst(0, 1'b0);
    base = xfer_cnt;
    en = 1'b1;
    wait_xfers(base + 9);
    chk("unlim_busy", 64'(busy), 64'd1);
    man_rdy = 0;
    en = 1'b0;
    cyc(2);
    man_rdy = 1;
    cyc(3);
    chk("unlim_count", 64'(xfer_cnt - base), 64'd10);
    check_idle("unlim_stop");
    armed = 0;

    // en dropped at beat 1 of an 8-beat burst
    cfg_len = LEN_W'(7); cfg_gap = GAP_W'(1); cfg_bursts = '0;
    exp_gap = 1;
    push_burst(7, 1'b0);
    base = xfer_cnt;
    en = 1'b1;
    wait_xfers(base + 1);
    en = 1'b0;
    cyc(20);
    chk("endrop_count", 64'(xfer_cnt - base), 64'd8);
    check_idle("endrop");
    armed = 0;

    // reset while beat 2 is stalled
    cfg_len = LEN_W'(3); cfg_gap = '0; cfg_bursts = '0;
    push_burst(3, 1'b0);
    base = xfer_cnt;
    en = 1'b1;
    wait_xfers(base + 2);
    man_rdy = 0;
    reset = 1'b0;
    en = 1'b0;
    cyc(1);
    chk("midrst_valid", 64'(bus.valid), 64'd0);
    chk("midrst_data", bus.data, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    m_inc = PW'(1); m_lfsr = 32'hFFFF_FFFF; m_burst = '0;
    armed = 0;
    cyc(2);
    reset = 1'b1;
    man_rdy = 1;
    cyc(1);
    run_bursts(1, 0, 1'b0, 1, 3);

    // randomized configurations under random backpressure
    for (int r = 0; r < 6; r++)
      run_bursts(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_tg_param.md
Name: stream_tg_param

Overview:
- Parametrised AXI-stream-style traffic generator for the cryp datapath benches.
- Emits repeated bursts of beats with programmable length, inter-burst gap, payload mode (incrementing or LFSR) and burst count.
- Uses a strict valid/ready handshake: data is held stable under backpressure.
- Replaces fixed-length, fixed-gap generators; sits in front of decode/encode cores under test.

Parameters:
- DATA_W, 64, beat width; must be ≥64 and a multiple of 8.
- LEN_W, 8, width of cfg_len.
- GAP_W, 8, width of cfg_gap.
- BCNT_W, 16, width of cfg_bursts and the burst index.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  run enable.
- cfg_len  in  LEN_W  beats per burst minus 1 (0 = 1 beat).
- cfg_gap  in  GAP_W  idle cycles between bursts.
- cfg_mode  in  1  payload mode: 0 = incrementing, 1 = LFSR.
- cfg_bursts  in  BCNT_W  number of bursts to send; 0 = unlimited.
- m_axi_ready  in  1  sink ready.
- m_axi_valid  out  1  beat valid.
- m_axi_data  out  DATA_W  beat data.
- m_axi_last  out  1  final beat of burst.
- busy  out  1  high in SEND or GAP.
- done  out  1  one-cycle pulse when cfg_bursts bursts have completed.

Behaviour:
- Reset (reset==0 at posedge):
  - Outputs: m_axi_valid=0, m_axi_last=0, m_axi_data=0, busy=0, done=0.
  - Internal: state=IDLE, burst_idx=0, beat_idx=0, inc counter=1, LFSR=32'hFFFF_FFFF.
  - Reset mid-burst drops valid immediately; no beat is completed.
- Handshake:
  - A beat transfers on a cycle where m_axi_valid && m_axi_ready.
  - Once valid is high, valid, data and last stay unchanged until that transfer.
  - valid never deasserts without a transfer, except on reset.
- Data format: m_axi_data = {payload[DATA_W-33:0], beat_idx zero-extended to 16 bits, burst_idx[15:0]}.
  - burst_idx occupies the LSBs; bits [31:16] are beat_idx.
  - For BCNT_W>16 only the low 16 bits of burst_idx appear in the data.
- Payload:
  - Mode 0: DATA_W-32-bit counter, starts at 1, +1 per transferred beat, wraps to 0, never cleared between bursts.
  - Mode 1: 32-bit Galois LFSR, taps x^32+x^22+x^2+x+1, advances once per transferred beat; its value is zero-extended into the payload field.
  - Both generators advance only on transfers, regardless of which mode is selected.
- Config sampling:
  - cfg_len, cfg_gap and cfg_mode are latched at each burst start (IDLE->SEND, GAP->SEND, or the back-to-back transition).
  - Changes to them mid-burst have no effect until the next burst starts.
  - cfg_bursts is latched on IDLE->SEND only.
- State machine: IDLE, SEND, GAP, DONE.
  - IDLE: if en=1, latch config and go to SEND. The first beat (beat_idx=0) has valid=1 on the cycle after en is sampled.
  - SEND, on each transfer: beat_idx++. m_axi_last=1 exactly on the beat with beat_idx==latched len.
  - SEND, on the last-beat transfer: burst_idx++.
    - If cfg_bursts≠0 and burst_idx+1==cfg_bursts: valid=0, done pulses next cycle, go to DONE.
    - Else if en=0: valid=0, go to IDLE.
    - Else if gap=0: back-to-back; next burst's beat 0 is presented the following cycle with valid held high.
    - Else: valid=0, go to GAP with gap counter=0.
  - GAP: valid=0; count cycles. After exactly cfg_gap cycles with valid low, start the next burst (beat 0 valid) if en=1, else go to IDLE. en=0 in GAP goes to IDLE on the next cycle.
  - DONE: hold outputs idle. When en=0, go to IDLE and clear burst_idx.
- en=0 during SEND: the current burst completes fully; the stop is honoured at the last beat.
- busy=1 in SEND and GAP.
- burst_idx wraps modulo 2^BCNT_W when cfg_bursts=0.
- Simultaneous events: cfg changes coinciding with a last transfer are sampled for the new burst. en falling on the last-beat cycle sends the block to IDLE.

Test Plan:
- cfg_len=3, gap=2, mode=0, bursts=2, ready=1 -> 4 beats, payload 1..4, beat_idx 0..3, last on 4th; 2 idle cycles; 4 beats, payload 5..8, burst_idx=1; done pulses once; valid low after.
- Same config with ready toggling 1,0,0,1,... -> each beat held stable while ready=0; beat sequence identical to the ready=1 case; no duplicated or skipped beat.
- gap=0, len=0, bursts=0 -> valid continuously high, last=1 every beat, burst_idx increments every beat.
- mode=1, len=2 -> payload beats 32'hFFFF_FFFF then successive Galois steps matching the reference model.
- en dropped at beat 1 of len=7 burst -> beats 2..7 still delivered, last on beat 7, then IDLE, busy=0.
- reset=0 asserted during beat 2 with ready=0 -> next cycle valid=0, data=0; after release with en=1, payload restarts at 1 and burst_idx=0.
